// File: rtl/mixcolumns_seq.sv
// Forward AES MixColumns engine, iterating COLS_PER_CYCLE columns per clock
// over one 128-bit state, with valid/ready handshakes on input and output.
module mixcolumns_seq #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] in_state,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] out_state,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned COL_W    = 32;
    localparam int unsigned STATE_W  = NUM_COLS * COL_W;
    localparam int unsigned N        = NUM_COLS / COLS_PER_CYCLE;
    localparam int unsigned CNT_W    = 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    // Only 1, 2 or 4 columns per cycle divide the state evenly.
    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
            $error("mixcolumns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [STATE_W-1:0]   work_q, work_d;

    // Multiply by x in GF(2^8) modulo 0x11b.
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // One column times the fixed MixColumns matrix; row 0 is the MSB byte.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        b3 = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        return {b0, b1, b2, b3};
    endfunction

    // Next-state logic: accept in IDLE, transform the counter's column group in BUSY, hold in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_state;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int c = 0; c < int'(NUM_COLS); c++) begin
                    if (CNT_W'(c / int'(COLS_PER_CYCLE)) == cnt_q) begin
                        work_d[STATE_W-1-COL_W*c -: COL_W] = mix_col(work_q[STATE_W-1-COL_W*c -: COL_W]);
                    end
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, working register and registered handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
        end
    end

    assign out_state = work_q;

endmodule

// File: tb/tb_mixcolumns_seq.sv
// Scoreboard bench for mixcolumns_seq: directed FIPS/column vectors, backpressure,
// mid-operation reset, random streaming, round trip, and wider COLS_PER_CYCLE latency.
module tb_mixcolumns_seq;

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] COL_IN   = 128'hdb135345f20a225cd4d4d4d52d26314c;
    localparam logic [127:0] COL_OUT  = 128'h8e4da1bc9fdc589dd5d5d7d64d7ebdf8;
    localparam logic [127:0] FIX_IN   = 128'hc6c6c6c601010101c6c6c6c601010101;

    logic         clk;
    logic         rst;
    logic [127:0] in_state;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_state;
    logic         out_valid;
    logic         out_ready;

    logic [127:0] in_state_w;
    logic         in_valid_w;
    logic         out_ready_w;
    logic         in_ready2, out_valid2, in_ready4, out_valid4;
    logic [127:0] out_state2, out_state4;

    typedef struct packed {
        logic [127:0] exp;
        logic [127:0] orig;
    } sb_t;

    sb_t sbq[$];
    int  checks   = 0;
    int  failures = 0;
    int  n_in     = 0;
    int  n_out    = 0;
    bit  rand_rdy = 0;

    mixcolumns_seq #(.COLS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .in_state(in_state), .in_valid(in_valid), .in_ready(in_ready),
        .out_state(out_state), .out_valid(out_valid), .out_ready(out_ready)
    );

    mixcolumns_seq #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .in_state(in_state_w), .in_valid(in_valid_w), .in_ready(in_ready2),
        .out_state(out_state2), .out_valid(out_valid2), .out_ready(out_ready_w)
    );

    mixcolumns_seq #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_state(in_state_w), .in_valid(in_valid_w), .in_ready(in_ready4),
        .out_state(out_state4), .out_valid(out_valid4), .out_ready(out_ready_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generic shift-and-add GF(2^8) multiply, poly 0x11b.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] coef(input int idx, input bit inv);
        case (idx)
            0:       return inv ? 8'h0e : 8'h02;
            1:       return inv ? 8'h0b : 8'h03;
            2:       return inv ? 8'h0d : 8'h01;
            default: return inv ? 8'h09 : 8'h01;
        endcase
    endfunction

    // Circulant-matrix reference: forward MixColumns, or inverse when inv=1.
    function automatic logic [127:0] mix_ref(input logic [127:0] s, input bit inv);
        logic [127:0] r;
        logic [7:0]   a [4];
        logic [7:0]   b;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
            for (int row = 0; row < 4; row++) begin
                b = 8'h00;
                for (int k = 0; k < 4; k++) b = b ^ gmul(coef((k - row + 4) % 4, inv), a[k]);
                r[127 - 32*c - 8*row -: 8] = b;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one block to the CPC=1 engine, queue its expectation, and check acceptance-to-valid latency.
    task automatic send(input logic [127:0] d, input logic [127:0] e);
        int t;
        sb_t item;
        t = 0;
        while (!in_ready && t < 200) begin
            tick();
            t++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout actual=0 required=1");
            return;
        end
        in_state  = d;
        in_valid  = 1'b1;
        item.exp  = e;
        item.orig = d;
        sbq.push_back(item);
        n_in++;
        tick();
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin
            tick();
            t++;
        end
        chk("latency_cpc1", 128'(t), 128'(4));
    endtask

    // Monitor: pop and compare on every output handshake, plus inverse round trip.
    always @(negedge clk) begin : monitor
        sb_t e;
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%h required=none", out_state);
            end else begin
                e = sbq.pop_front();
                chk("out_state", out_state, e.exp);
                chk("round_trip", mix_ref(out_state, 1'b1), e.orig);
                n_out++;
            end
        end
    end

    // Random downstream backpressure during streaming.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;
        int           f2, f4, t;

        rst         = 1'b1;
        in_state    = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        in_state_w  = '0;
        in_valid_w  = 1'b0;
        out_ready_w = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_state", out_state, '0);
        chk("rst_in_ready_cpc2", 128'(in_ready2), 128'(1));
        chk("rst_in_ready_cpc4", 128'(in_ready4), 128'(1));

        // FIPS-197 vector and column vectors on CPC=1
        send(FIPS_IN, FIPS_OUT);
        send(COL_IN, COL_OUT);
        send(FIX_IN, FIX_IN);

        // FIPS-197 vector on CPC=2 and CPC=4: latency N=2 and N=1
        in_state_w = FIPS_IN;
        in_valid_w = 1'b1;
        tick();
        in_valid_w = 1'b0;
        f2 = 0;
        f4 = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (out_valid2 && f2 == 0) f2 = i;
            if (out_valid4 && f4 == 0) f4 = i;
        end
        chk("latency_cpc2", 128'(f2), 128'(2));
        chk("latency_cpc4", 128'(f4), 128'(1));
        chk("fips_cpc2", out_state2, FIPS_OUT);
        chk("fips_cpc4", out_state4, FIPS_OUT);
        out_ready_w = 1'b1;
        tick();
        chk("cpc2_drained", 128'(out_valid2), 128'(0));
        chk("cpc4_in_ready", 128'(in_ready4), 128'(1));
        out_ready_w = 1'b0;

        // Backpressure in DONE: stable output, in_valid pulse ignored
        out_ready = 1'b0;
        send(FIPS_IN, FIPS_OUT);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 3);
            in_state = COL_IN;
            tick();
            chk("bp_out_valid", 128'(out_valid), 128'(1));
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            chk("bp_out_state", out_state, FIPS_OUT);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

        // Reset after two column cycles: block discarded
        in_state = COL_IN;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", 128'(in_ready), 128'(1));
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_out_state", out_state, '0);
        send(COL_IN, COL_OUT);

        // Random streaming with input gaps and random out_ready
        rand_rdy = 1;
        for (int n = 0; n < 100; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            d = {$urandom, $urandom, $urandom, $urandom};
            send(d, mix_ref(d, 1'b0));
        end
        t = 0;
        while (sbq.size() != 0 && t < 200) begin
            tick();
            t++;
        end
        rand_rdy = 0;
        tick();
        out_ready = 1'b1;
        repeat (4) tick();

        chk("count_in_out", 128'(n_out), 128'(n_in));
        chk("queue_empty", 128'(sbq.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
